// File: rtl/if_fetch_pkg.sv
// Shared constants and state encoding for the instruction-fetch stage.
package if_fetch_pkg;

  localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;
  localparam logic        STOP       = 1'b1;
  localparam logic        NO_STOP    = 1'b0;
  localparam logic        RST_ENABLE = 1'b0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_HOLD,
    S_HOLD_PC,
    S_DROP
  } fetch_state_e;

  function automatic logic [31:0] seq_addr(input logic [31:0] addr);
    return addr + 32'd4;
  endfunction

endpackage

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC owner and instruction-bus master feeding if_id,
// with MIPS delay-slot branch handling and exception flush.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_address_i,
  output logic        ibus_req,
  output logic [31:0] ibus_addr,
  input  logic        ibus_ack,
  input  logic [31:0] ibus_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        stallreq_from_if
);

  fetch_state_e state_q, state_d;
  logic [31:0]  req_addr_q, req_addr_d;
  logic [31:0]  drop_target_q, drop_target_d;
  logic [31:0]  br_target_q, br_target_d;
  logic [31:0]  hold_inst_q, hold_inst_d;
  logic         br_pend_q, br_pend_d;
  logic [31:0]  next_addr;
  logic [31:0]  accept_addr;
  logic         unused_stall;

  assign unused_stall = ^stall[5:2];
  assign ibus_addr    = req_addr_q;

  // A branch arriving in the same cycle its delay slot is accepted redirects directly.
  assign next_addr   = br_pend_q ? br_target_q : seq_addr(req_addr_q);
  assign accept_addr = branch_flag_i ? branch_target_address_i : next_addr;

  always_comb begin
    state_d          = state_q;
    req_addr_d       = req_addr_q;
    drop_target_d    = drop_target_q;
    br_target_d      = br_target_q;
    hold_inst_d      = hold_inst_q;
    br_pend_d        = br_pend_q;
    ibus_req         = 1'b0;
    if_pc            = ZERO_WORD;
    if_inst          = ZERO_WORD;
    stallreq_from_if = 1'b0;

    if (branch_flag_i) begin
      br_pend_d   = 1'b1;
      br_target_d = branch_target_address_i;
    end

    case (state_q)
      S_IDLE: begin
        stallreq_from_if = 1'b1;
        state_d          = S_REQ;
        if (flush) begin
          br_pend_d  = 1'b0;
          req_addr_d = new_pc;
        end
      end
      S_REQ: begin
        ibus_req         = 1'b1;
        stallreq_from_if = !ibus_ack;
        if (flush) begin
          br_pend_d = 1'b0;
          if (ibus_ack) begin
            req_addr_d = new_pc;
          end else begin
            drop_target_d = new_pc;
            state_d       = S_DROP;
          end
        end else if (ibus_ack) begin
          if (stall[1] == NO_STOP) begin
            if_pc      = req_addr_q;
            if_inst    = ibus_rdata;
            req_addr_d = accept_addr;
            br_pend_d  = 1'b0;
            state_d    = (stall[0] == NO_STOP) ? S_REQ : S_HOLD_PC;
          end else begin
            hold_inst_d = ibus_rdata;
            state_d     = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (flush) begin
          br_pend_d  = 1'b0;
          req_addr_d = new_pc;
          state_d    = S_REQ;
        end else begin
          // req_addr_q still names the held instruction until it is released.
          if_pc   = req_addr_q;
          if_inst = hold_inst_q;
          if (stall[1] == NO_STOP) begin
            req_addr_d = accept_addr;
            br_pend_d  = 1'b0;
            state_d    = S_REQ;
          end
        end
      end
      S_HOLD_PC: begin
        if (flush) begin
          br_pend_d  = 1'b0;
          req_addr_d = new_pc;
          state_d    = S_REQ;
        end else if (stall[0] == NO_STOP) begin
          state_d = S_REQ;
        end
      end
      S_DROP: begin
        ibus_req         = 1'b1;
        stallreq_from_if = 1'b1;
        if (flush) begin
          br_pend_d = 1'b0;
          if (ibus_ack) begin
            req_addr_d = new_pc;
            state_d    = S_REQ;
          end else begin
            drop_target_d = new_pc;
          end
        end else if (ibus_ack) begin
          req_addr_d = drop_target_q;
          state_d    = S_REQ;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q       <= S_IDLE;
      req_addr_q    <= RESET_PC;
      drop_target_q <= RESET_PC;
      br_target_q   <= ZERO_WORD;
      hold_inst_q   <= ZERO_WORD;
      br_pend_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_addr_q    <= req_addr_d;
      drop_target_q <= drop_target_d;
      br_target_q   <= br_target_d;
      hold_inst_q   <= hold_inst_d;
      br_pend_q     <= br_pend_d;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Directed vector bench for if_fetch: one table row per clock cycle,
// inputs driven on the falling edge and outputs checked 1ns later.
module tb_if_fetch;

  typedef struct {
    logic        rstN;
    logic [5:0]  stallVec;
    logic        flushIn;
    logic [31:0] newPc;
    logic        brFlag;
    logic [31:0] brTarget;
    logic        ack;
    logic [31:0] rdata;
    logic        expReq;
    logic [31:0] expAddr;
    logic [31:0] expPc;
    logic [31:0] expInst;
    logic        expStallreq;
  } vector_t;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        branch_flag_i;
  logic [31:0] branch_target_address_i;
  logic        ibus_req;
  logic [31:0] ibus_addr;
  logic        ibus_ack;
  logic [31:0] ibus_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        stallreq_from_if;

  int vectorsApplied = 0;
  int miscompares    = 0;
  vector_t vecs[$];

  if_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .stall                   (stall),
    .flush                   (flush),
    .new_pc                  (new_pc),
    .branch_flag_i           (branch_flag_i),
    .branch_target_address_i (branch_target_address_i),
    .ibus_req                (ibus_req),
    .ibus_addr               (ibus_addr),
    .ibus_ack                (ibus_ack),
    .ibus_rdata              (ibus_rdata),
    .if_pc                   (if_pc),
    .if_inst                 (if_inst),
    .stallreq_from_if        (stallreq_from_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vector_t mk(input logic r, input logic [5:0] s, input logic f,
                                 input logic [31:0] np, input logic b, input logic [31:0] bt,
                                 input logic a, input logic [31:0] rd,
                                 input logic eReq, input logic [31:0] eAddr,
                                 input logic [31:0] ePc, input logic [31:0] eInst,
                                 input logic eStall);
    vector_t v;
    v.rstN = r; v.stallVec = s; v.flushIn = f; v.newPc = np;
    v.brFlag = b; v.brTarget = bt; v.ack = a; v.rdata = rd;
    v.expReq = eReq; v.expAddr = eAddr; v.expPc = ePc;
    v.expInst = eInst; v.expStallreq = eStall;
    return v;
  endfunction

  task automatic applyStimulus(input vector_t v);
    @(negedge clk);
    rst                     = v.rstN;
    stall                   = v.stallVec;
    flush                   = v.flushIn;
    new_pc                  = v.newPc;
    branch_flag_i           = v.brFlag;
    branch_target_address_i = v.brTarget;
    ibus_ack                = v.ack;
    ibus_rdata              = v.rdata;
    #1;
  endtask

  // ibus_addr is only meaningful while a request is raised.
  task automatic checkOutput(input vector_t v, input string name);
    logic ok;
    vectorsApplied++;
    ok = (ibus_req === v.expReq) && (!v.expReq || ibus_addr === v.expAddr) &&
         (if_pc === v.expPc) && (if_inst === v.expInst) &&
         (stallreq_from_if === v.expStallreq);
    if (!ok) begin
      miscompares++;
      $display("[TB] FAIL %s: got req=%0b addr=%h pc=%h inst=%h stallreq=%0b, want req=%0b addr=%h pc=%h inst=%h stallreq=%0b",
               name, ibus_req, ibus_addr, if_pc, if_inst, stallreq_from_if,
               v.expReq, v.expAddr, v.expPc, v.expInst, v.expStallreq);
    end
  endtask

  task automatic runVector(input vector_t v, input string name);
    applyStimulus(v);
    checkOutput(v, name);
  endtask

  initial begin
    rst = 1'b0; stall = 6'd0; flush = 1'b0; new_pc = 32'd0;
    branch_flag_i = 1'b0; branch_target_address_i = 32'd0;
    ibus_ack = 1'b0; ibus_rdata = 32'd0;

    // Reset, then zero-wait fetches from 0.
    vecs.push_back(mk(0, 6'd0, 0, 32'h0, 0, 32'h0, 0, 32'h0,          0, 32'h0,  32'h0,  32'h0,          1));
    vecs.push_back(mk(1, 6'd0, 0, 32'h0, 0, 32'h0, 0, 32'h0,          0, 32'h0,  32'h0,  32'h0,          1));
    vecs.push_back(mk(1, 6'd0, 0, 32'h0, 0, 32'h0, 1, 32'h1000_0000,  1, 32'h0,  32'h0,  32'h1000_0000,  0));
    vecs.push_back(mk(1, 6'd0, 0, 32'h0, 0, 32'h0, 1, 32'h1000_0004,  1, 32'h4,  32'h4,  32'h1000_0004,  0));
    vecs.push_back(mk(1, 6'd0, 0, 32'h0, 0, 32'h0, 1, 32'h1000_0008,  1, 32'h8,  32'h8,  32'h1000_0008,  0));
    vecs.push_back(mk(1, 6'd0, 0, 32'h0, 0, 32'h0, 1, 32'h1000_000C,  1, 32'hC,  32'hC,  32'h1000_000C,  0));
    // Three wait cycles at 0x10; rdata is junk until ack.
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(1, 6'd0, 0, 32'h0, 0, 32'h0, 0, 32'hDEAD_BEEF, 1, 32'h10, 32'h0,  32'h0,          1));
    vecs.push_back(mk(1, 6'd0, 0, 32'h0, 0, 32'h0, 1, 32'h1000_0010,  1, 32'h10, 32'h10, 32'h1000_0010,  0));
    vecs.push_back(mk(1, 6'd0, 0, 32'h0, 0, 32'h0, 1, 32'h1000_0014,  1, 32'h14, 32'h14, 32'h1000_0014,  0));
    vecs.push_back(mk(1, 6'd0, 0, 32'h0, 0, 32'h0, 1, 32'h1000_0018,  1, 32'h18, 32'h18, 32'h1000_0018,  0));
    vecs.push_back(mk(1, 6'd0, 0, 32'h0, 0, 32'h0, 1, 32'h1000_001C,  1, 32'h1C, 32'h1C, 32'h1000_001C,  0));
    vecs.push_back(mk(1, 6'd0, 0, 32'h0, 0, 32'h0, 1, 32'h1000_0020,  1, 32'h20, 32'h20, 32'h1000_0020,  0));
    // Branch to 0x100 while delay slot 0x24 is outstanding.
    vecs.push_back(mk(1, 6'd0, 0, 32'h0, 1, 32'h100, 0, 32'h0,        1, 32'h24, 32'h0,  32'h0,          1));
    vecs.push_back(mk(1, 6'd0, 0, 32'h0, 0, 32'h0, 0, 32'h0,          1, 32'h24, 32'h0,  32'h0,          1));
    vecs.push_back(mk(1, 6'd0, 0, 32'h0, 0, 32'h0, 1, 32'h1000_0024,  1, 32'h24, 32'h24, 32'h1000_0024,  0));
    vecs.push_back(mk(1, 6'd0, 0, 32'h0, 0, 32'h0, 1, 32'h1000_0100,  1, 32'h100, 32'h100, 32'h1000_0100, 0));
    vecs.push_back(mk(1, 6'd0, 0, 32'h0, 0, 32'h0, 1, 32'h1000_0104,  1, 32'h104, 32'h104, 32'h1000_0104, 0));
    // Branch coincident with delay-slot acceptance goes straight to 0x40.
    vecs.push_back(mk(1, 6'd0, 0, 32'h0, 1, 32'h40, 1, 32'h1000_0108, 1, 32'h108, 32'h108, 32'h1000_0108, 0));
    // Pending branch, then flush to 0x180 while 0x40 is outstanding.
    vecs.push_back(mk(1, 6'd0, 0, 32'h0,   1, 32'h200, 0, 32'h0,      1, 32'h40, 32'h0,  32'h0,          1));
    vecs.push_back(mk(1, 6'd0, 1, 32'h180, 0, 32'h0,   0, 32'h0,      1, 32'h40, 32'h0,  32'h0,          1));
    vecs.push_back(mk(1, 6'd0, 0, 32'h0,   0, 32'h0,   0, 32'h0,      1, 32'h40, 32'h0,  32'h0,          1));
    vecs.push_back(mk(1, 6'd0, 0, 32'h0,   0, 32'h0,   1, 32'hBAD0_0040, 1, 32'h40, 32'h0, 32'h0,        1));
    vecs.push_back(mk(1, 6'd0, 0, 32'h0,   0, 32'h0,   1, 32'h1000_0180, 1, 32'h180, 32'h180, 32'h1000_0180, 0));
    // 0x184 proves the branch to 0x200 was cleared; flush-with-ack redirects to 0x50.
    vecs.push_back(mk(1, 6'd0, 1, 32'h50,  0, 32'h0,   1, 32'h1000_0184, 1, 32'h184, 32'h0, 32'h0,       0));
    // IF stall on ack of 0x50 for two cycles.
    vecs.push_back(mk(1, 6'd3, 0, 32'h0, 0, 32'h0, 1, 32'h1000_0050,  1, 32'h50, 32'h0,  32'h0,          0));
    vecs.push_back(mk(1, 6'd3, 0, 32'h0, 0, 32'h0, 0, 32'h0,          0, 32'h50, 32'h50, 32'h1000_0050,  0));
    vecs.push_back(mk(1, 6'd0, 0, 32'h0, 0, 32'h0, 0, 32'h0,          0, 32'h50, 32'h50, 32'h1000_0050,  0));
    vecs.push_back(mk(1, 6'd0, 0, 32'h0, 0, 32'h0, 1, 32'h1000_0054,  1, 32'h54, 32'h54, 32'h1000_0054,  0));
    // PC stall only: instruction delivered, then idle bus.
    vecs.push_back(mk(1, 6'd1, 0, 32'h0, 0, 32'h0, 1, 32'h1000_0058,  1, 32'h58, 32'h58, 32'h1000_0058,  0));
    vecs.push_back(mk(1, 6'd1, 0, 32'h0, 0, 32'h0, 0, 32'h0,          0, 32'h5C, 32'h0,  32'h0,          0));
    vecs.push_back(mk(1, 6'd0, 0, 32'h0, 0, 32'h0, 0, 32'h0,          0, 32'h5C, 32'h0,  32'h0,          0));
    vecs.push_back(mk(1, 6'd0, 0, 32'h0, 0, 32'h0, 1, 32'h1000_005C,  1, 32'h5C, 32'h5C, 32'h1000_005C,  0));
    // Address wrap at the top of memory.
    vecs.push_back(mk(1, 6'd0, 1, 32'hFFFF_FFFC, 0, 32'h0, 1, 32'h1000_0060, 1, 32'h60, 32'h0, 32'h0,    0));
    vecs.push_back(mk(1, 6'd0, 0, 32'h0, 0, 32'h0, 1, 32'h1000_FFFC,  1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h1000_FFFC, 0));
    vecs.push_back(mk(1, 6'd0, 0, 32'h0, 0, 32'h0, 1, 32'h2000_0000,  1, 32'h0,  32'h0,  32'h2000_0000,  0));

    @(posedge clk);
    for (int i = 0; i < vecs.size(); i++)
      runVector(vecs[i], $sformatf("vec%0d", i));

    // Reset while 0x4 is outstanding; fetch restarts from RESET_PC.
    runVector(mk(0, 6'd0, 0, 32'h0, 0, 32'h0, 0, 32'h0,         1, 32'h4, 32'h0, 32'h0,         1), "rstMidReq");
    runVector(mk(0, 6'd0, 0, 32'h0, 0, 32'h0, 0, 32'h0,         0, 32'h0, 32'h0, 32'h0,         1), "rstHeld");
    runVector(mk(1, 6'd0, 0, 32'h0, 0, 32'h0, 0, 32'h0,         0, 32'h0, 32'h0, 32'h0,         1), "rstIdle");
    runVector(mk(1, 6'd0, 0, 32'h0, 0, 32'h0, 1, 32'h3000_0000, 1, 32'h0, 32'h0, 32'h3000_0000, 0), "rstRestart0");
    runVector(mk(1, 6'd0, 0, 32'h0, 0, 32'h0, 1, 32'h3000_0004, 1, 32'h4, 32'h4, 32'h3000_0004, 0), "rstRestart4");

    // Second flush while draining: the later target wins.
    runVector(mk(1, 6'd0, 1, 32'h300, 0, 32'h0, 0, 32'h0,         1, 32'h8, 32'h0, 32'h0,         1), "dropEnter");
    runVector(mk(1, 6'd0, 1, 32'h400, 0, 32'h0, 0, 32'h0,         1, 32'h8, 32'h0, 32'h0,         1), "dropReflush");
    runVector(mk(1, 6'd0, 0, 32'h0,   0, 32'h0, 1, 32'hBAD0_0008, 1, 32'h8, 32'h0, 32'h0,         1), "dropAck");
    runVector(mk(1, 6'd0, 0, 32'h0,   0, 32'h0, 1, 32'h3000_0400, 1, 32'h400, 32'h400, 32'h3000_0400, 0), "dropTarget");

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
